// File: rtl/rr_mux4.sv
// Four-source round-robin merge onto one registered valid/ready channel, tagged with source index.
// Optional packet locking (in_last/out_last) is enabled by defining RR_MUX4_PKT_LOCK_EN.
module rr_mux4 #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [3:0]          in_valid,
  output logic [3:0]          in_ready,
`ifdef RR_MUX4_PKT_LOCK_EN
  input  logic [3:0]          in_last,
  output logic                out_last,
`endif
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_sel,
  output logic                out_valid,
  input  logic                out_ready
);

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_sel_q, out_sel_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        last_q, last_d;
  logic              lock_q, lock_d;
  logic [1:0]        lock_ch_q, lock_ch_d;
  logic              out_last_q, out_last_d;

  logic [DATA_W-1:0] ch_data_s [4];
  logic [3:0]        req_s;
  logic [2:0]        pick_s;
  logic [1:0]        gnt_s;
  logic              load_en_s;
  logic              take_s;
  logic              gnt_last_s;

  // First requester after 'last' in circular order; result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      c = last + k[1:0];
      if (req[c]) begin
        res = {1'b1, c};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration, handshake and next-state selection.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch_data_s[i] = in_data[i*DATA_W +: DATA_W];
    end
    load_en_s = !out_valid_q || out_ready;
    if (lock_q) begin
      req_s = in_valid & (4'b0001 << lock_ch_q);
    end else begin
      req_s = in_valid;
    end
    pick_s = rr_pick(req_s, last_q);
    gnt_s  = pick_s[1:0];
    take_s = rst_n && load_en_s && pick_s[2];
`ifdef RR_MUX4_PKT_LOCK_EN
    gnt_last_s = in_last[gnt_s];
`else
    gnt_last_s = 1'b1;
`endif

    in_ready    = 4'b0000;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last_q;

    if (take_s) begin
      in_ready[gnt_s] = 1'b1;
      out_data_d      = ch_data_s[gnt_s];
      out_sel_d       = gnt_s;
      out_valid_d     = 1'b1;
      last_d          = gnt_s;
      // A non-final beat pins arbitration to this source until its last beat goes through.
      lock_d          = !gnt_last_s;
      lock_ch_d       = gnt_s;
      out_last_d      = gnt_last_s;
    end else if (load_en_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= {DATA_W{1'b0}};
      out_sel_q   <= 2'b00;
      out_valid_q <= 1'b0;
      last_q      <= 2'b11;
      lock_q      <= 1'b0;
      lock_ch_q   <= 2'b00;
      out_last_q  <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
`ifdef RR_MUX4_PKT_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule
